// File: rtl/sm4_pkg.sv
// SM4 shared constants and helpers.
// FK words, S-box, CK generator and FSM states.
package sm4_pkg;

    localparam int SM4_ROUNDS = 32;
    localparam int SM4_IDX_W  = 5;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [7:0] SM4_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7,
        8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3,
        8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a,
        8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95,
        8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba,
        8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b,
        8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2,
        8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52,
        8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5,
        8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55,
        8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60,
        8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f,
        8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f,
        8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd,
        8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e,
        8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20,
        8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [7:0] sm4_sbox(input logic [7:0] x);
        return SM4_SBOX[x];
    endfunction

    // CK byte j of round i is ((4i+j)*7) mod 256, MSB first.
    function automatic logic [31:0] sm4_ck(input logic [4:0] i);
        logic [31:0] w;
        logic [7:0]  n;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            n = {1'b0, i, 2'b00} + 8'(j);
            w[31-8*j -: 8] = n * 8'd7;
        end
        return w;
    endfunction

endpackage

// File: rtl/round_key_expansion.sv
// One SM4 key-expansion round, purely combinational.
// result = {K1, K2, K3, K0 ^ T'(K1 ^ K2 ^ K3 ^ CK)}.
module round_key_expansion
    import sm4_pkg::*;
(
    input  logic [127:0] data,
    input  logic [31:0]  cki,
    output logic [127:0] result
);

    logic [31:0] w_x;
    logic [31:0] w_b;
    logic [31:0] w_l;

    // Nonlinear tau followed by the key-schedule linear map L'.
    always_comb begin
        w_x = data[95:64] ^ data[63:32] ^ data[31:0] ^ cki;
        w_b = {sm4_sbox(w_x[31:24]), sm4_sbox(w_x[23:16]),
               sm4_sbox(w_x[15:8]),  sm4_sbox(w_x[7:0])};
        w_l = w_b
            ^ {w_b[18:0], w_b[31:19]}
            ^ {w_b[8:0],  w_b[31:9]};
        result = {data[95:0], data[127:96] ^ w_l};
    end

endmodule

// File: rtl/sm4_key_schedule.sv
// Sequential SM4 key schedule: one round per cycle,
// 32 round keys stored and served via a registered read port.
module sm4_key_schedule
    import sm4_pkg::*;
#(
    parameter int NUM_ROUNDS = SM4_ROUNDS,
    parameter int IDX_W      = SM4_IDX_W
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         keys_valid,
    input  logic         rk_rd_en,
    input  logic [4:0]   rk_rd_idx,
    input  logic         rk_decrypt,
    output logic [31:0]  rk_out,
    output logic         rk_out_valid
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_cnt;
    logic [127:0]     r_k;
    logic             r_keys_valid;
    logic [31:0]      r_rk [NUM_ROUNDS];
    logic [31:0]      r_rk_out;
    logic             r_rk_out_valid;

    logic [31:0]      w_ck;
    logic [127:0]     w_res;
    logic [127:0]     w_k_init;
    logic             w_load;
    logic [IDX_W-1:0] w_rd_idx;

    // Combinational round constant and whitened key.
    always_comb begin
        w_ck     = sm4_ck(r_cnt);
        w_k_init = key_in ^ {FK0, FK1, FK2, FK3};
        w_load   = key_valid && (r_state != ST_EXPAND);
        w_rd_idx = rk_decrypt ? (LAST - rk_rd_idx) : rk_rd_idx;
    end

    round_key_expansion u_rke (
        .data   (r_k),
        .cki    (w_ck),
        .result (w_res)
    );

    // Control FSM: idle/done accept a key, expand runs 32 rounds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_keys_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_load) begin
                        r_k          <= w_k_init;
                        r_cnt        <= '0;
                        r_keys_valid <= 1'b0;
                        r_state      <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    r_k   <= w_res;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state      <= ST_DONE;
                        r_keys_valid <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Round-key storage; contents are qualified by keys_valid only.
    always_ff @(posedge clk) begin
        if (r_state == ST_EXPAND) begin
            r_rk[r_cnt] <= w_res[31:0];
        end
    end

    // Registered read port with one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rk_out       <= '0;
            r_rk_out_valid <= 1'b0;
        end else begin
            r_rk_out_valid <= rk_rd_en;
            if (rk_rd_en) begin
                r_rk_out <= r_rk[w_rd_idx];
            end
        end
    end

    assign key_ready    = (r_state != ST_EXPAND);
    assign busy         = (r_state == ST_EXPAND);
    assign keys_valid   = r_keys_valid;
    assign rk_out       = r_rk_out;
    assign rk_out_valid = r_rk_out_valid;

endmodule

// File: tb/tb_sm4_key_schedule.sv
// Bench for sm4_key_schedule: directed loads and reads,
// read data checked by a queue-based scoreboard.
module tb_sm4_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         busy;
    logic         keys_valid;
    logic         rk_rd_en;
    logic [4:0]   rk_rd_idx;
    logic         rk_decrypt;
    logic [31:0]  rk_out;
    logic         rk_out_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] val;
        int          tag;
    } exp_t;

    exp_t sbq[$];

    localparam logic [127:0] MK_A = 128'h0123456789ABCDEFFEDCBA9876543210;

    logic [7:0] sb_tab [0:255] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7,
        8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3,
        8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a,
        8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95,
        8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba,
        8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b,
        8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2,
        8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52,
        8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5,
        8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55,
        8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60,
        8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f,
        8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f,
        8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd,
        8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e,
        8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20,
        8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    logic [31:0] mdl [32];
    logic [31:0] m_a [32];
    logic [31:0] m_z [32];

    sm4_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_in       (key_in),
        .busy         (busy),
        .keys_valid   (keys_valid),
        .rk_rd_en     (rk_rd_en),
        .rk_rd_idx    (rk_rd_idx),
        .rk_decrypt   (rk_decrypt),
        .rk_out       (rk_out),
        .rk_out_valid (rk_out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Software reference for the whole key schedule.
    task automatic compute_model(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ck;
        logic [31:0] t;
        logic [31:0] b;
        int          v;
        k[0] = mk[127:96] ^ 32'hA3B1BAC6;
        k[1] = mk[95:64]  ^ 32'h56AA3350;
        k[2] = mk[63:32]  ^ 32'h677D9197;
        k[3] = mk[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            ck = 32'h0;
            for (int j = 0; j < 4; j++) begin
                v  = ((4 * i + j) * 7) % 256;
                ck = (ck << 8) | 32'(v);
            end
            t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
            b = {sb_tab[t[31:24]], sb_tab[t[23:16]],
                 sb_tab[t[15:8]],  sb_tab[t[7:0]]};
            k[i+4] = k[i] ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
            mdl[i] = k[i+4];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rk_out_valid cycle consumes one expected entry.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rk_out_valid === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL rk_extra: rk_out_valid with %h, nothing expected",
                         rk_out);
            end else begin
                e = sbq.pop_front();
                if (rk_out !== e.val) begin
                    errors++;
                    $display("FAIL rk_read[%0d]: got %h, expected %h",
                             e.tag, rk_out, e.val);
                end
            end
        end
    end

    // Issue one read request; called at posedge+1.
    task automatic rd(input int idx, input bit dec, input logic [31:0] exp);
        exp_t e;
        rk_rd_en   = 1'b1;
        rk_rd_idx  = 5'(idx);
        rk_decrypt = dec;
        e.val = exp;
        e.tag = idx;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        rk_rd_en = 1'b0;
    endtask

    // Load a key and follow the expansion to completion.
    task automatic run_expand(input logic [127:0] mk, input bit hold,
                              input bit rd_same, input logic [31:0] rd_exp,
                              output int bcnt, output int kvlat,
                              output logic kv0);
        exp_t e;
        key_valid = 1'b1;
        key_in    = mk;
        if (rd_same) begin
            rk_rd_en   = 1'b1;
            rk_rd_idx  = 5'd0;
            rk_decrypt = 1'b0;
            e.val = rd_exp;
            e.tag = 0;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        kv0   = keys_valid;
        bcnt  = 0;
        kvlat = -1;
        rk_rd_en = 1'b0;
        if (hold) key_in = ~mk;
        else      key_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bcnt++;
            if (keys_valid) begin
                kvlat = i;
                break;
            end
            if (hold && i == 30) key_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
    endtask

    initial begin
        int   bc;
        int   kl;
        logic k0;

        compute_model(MK_A);
        for (int i = 0; i < 32; i++) m_a[i] = mdl[i];
        compute_model(128'h0);
        for (int i = 0; i < 32; i++) m_z[i] = mdl[i];

        rst        = 1'b1;
        key_valid  = 1'b0;
        key_in     = '0;
        rk_rd_en   = 1'b0;
        rk_rd_idx  = '0;
        rk_decrypt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_ready", key_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_keys_valid", keys_valid, 0);
        check("rst_rk_out", rk_out, 0);
        check("rst_rk_out_valid", rk_out_valid, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Main key, single-cycle handshake.
        run_expand(MK_A, 1'b0, 1'b0, 32'h0, bc, kl, k0);
        check("a_busy_cycles", bc, 32);
        check("a_kv_latency", kl, 32);
        check("a_key_ready_done", key_ready, 1);
        rd(0, 1'b0, 32'hF12186F9);
        rd(31, 1'b0, 32'h9124A012);
        rd(0, 1'b1, 32'h9124A012);
        rd(31, 1'b1, 32'hF12186F9);
        @(posedge clk);
        #1;
        rd(5, 1'b1, m_a[26]);
        @(posedge clk);
        #1;

        // Back-to-back reads, no bubbles.
        for (int i = 0; i < 32; i++) rd(i, 1'b0, m_a[i]);
        @(posedge clk);
        #1;

        // key_valid held with a different key during expansion.
        run_expand(MK_A, 1'b1, 1'b0, 32'h0, bc, kl, k0);
        check("h_busy_cycles", bc, 32);
        check("h_kv_latency", kl, 32);
        rd(31, 1'b0, 32'h9124A012);
        rd(0, 1'b0, 32'hF12186F9);

        // Reset in the middle of an expansion.
        key_valid = 1'b1;
        key_in    = 128'h0;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("r_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("r_busy", busy, 0);
        check("r_keys_valid", keys_valid, 0);
        check("r_key_ready", key_ready, 1);
        run_expand(MK_A, 1'b0, 1'b0, 32'h0, bc, kl, k0);
        check("r_busy_cycles", bc, 32);
        check("r_kv_latency", kl, 32);
        rd(0, 1'b0, 32'hF12186F9);
        rd(31, 1'b0, 32'h9124A012);

        // New all-zero key from DONE with a read in the load cycle.
        run_expand(128'h0, 1'b0, 1'b1, 32'hF12186F9, bc, kl, k0);
        check("z_kv_dropped", k0, 0);
        check("z_busy_cycles", bc, 32);
        check("z_kv_latency", kl, 32);
        for (int i = 0; i < 32; i++) rd(i, 1'b1, m_z[31-i]);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sm4_key_schedule.md
Name: sm4_key_schedule

Overview:
Sequential SM4 key schedule that sits directly upstream of the encrypt/decrypt round datapath.
- Accepts a 128-bit master key MK and XORs it with FK.
- Iterates the single-round key expansion once per cycle for 32 cycles, generating CK on the fly.
- Stores rk0..rk31 in an internal register file.
- Serves round keys to the cipher core through a registered read port, with optional reverse ordering for decryption.

Parameters:
NUM_ROUNDS, 32, number of round keys generated and stored (fixed for SM4; used for counter and array sizing)
IDX_W, 5, width of round counter and read index (log2 NUM_ROUNDS)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
key_valid  input  1  master key offered this cycle
key_ready  output  1  block can accept a new master key
key_in  input  128  master key MK, word MK0 in bits [127:96]
busy  output  1  expansion in progress
keys_valid  output  1  all 32 round keys are stored and stable
rk_rd_en  input  1  read request for a round key
rk_rd_idx  input  5  cipher round number, 0..31
rk_decrypt  input  1  1 = map index to 31-rk_rd_idx (decryption order)
rk_out  output  32  registered round key
rk_out_valid  output  1  rk_out holds data for the request made the previous cycle

Behaviour:
- Reset values:
  - State IDLE.
  - key_ready=1, busy=0, keys_valid=0, rk_out=0, rk_out_valid=0.
  - Round counter 0.
  - The key array is not cleared; it is qualified by keys_valid.
- States:
  - IDLE: key_ready=1. On key_valid, load K = key_in ^ {A3B1BAC6, 56AA3350, 677D9197, B27022DC}, counter=0, go to EXPAND.
  - EXPAND: key_ready=0, busy=1. Each cycle:
    - Apply one key-expansion round to K with CK[counter].
    - Write the new word (result[31:0]) to rk[counter].
    - Update K to the round result and increment the counter.
    - After the write at counter=31, go to DONE.
    - Duration: exactly 32 cycles.
  - DONE: keys_valid=1, busy=0, key_ready=1. On key_valid, load the new key as in IDLE, go to EXPAND, and clear keys_valid in that same cycle.
- Timing:
  - Handshake at edge T: busy=1 from T+1 through T+32.
  - rk31 is written at edge T+32.
  - keys_valid=1 from T+33.
  - key_valid while busy is ignored (key_ready=0); no queuing.
- CK generation:
  - CK[i] byte j (j=0 is MSB) = ((4i+j)*7) mod 256.
  - Computed combinationally from the counter: 8-bit multiply, truncated.
  - Examples: CK[0]=00070E15, CK[31]=646B7279.
- Read port:
  - Effective index = rk_decrypt ? 31-rk_rd_idx : rk_rd_idx (5-bit subtraction, no wrap issues).
  - If rk_rd_en at edge N, then at edge N+1 rk_out = rk[effective index] and rk_out_valid=1; otherwise rk_out_valid=0 and rk_out holds its value.
  - Reads while keys_valid=0 still return array contents; the consumer must gate on keys_valid.
- Simultaneous events:
  - A rk_rd_en in the same cycle as a new key load returns the old array value, because the write of rk0 happens one edge later.
- Reset mid-EXPAND: next cycle is IDLE, keys_valid=0, and the partial array is discarded logically.

Decomposition:
- Shared package sm4_pkg holds:
  - FK0..FK3 constants.
  - NUM_ROUNDS.
  - The CK byte function (or a 32-entry CK constant table).
  - State enum IDLE/EXPAND/DONE.
- Natural sub-module: instantiate the existing combinational round_key_expansion (data, cki, result) for the per-cycle round. Nothing else is split out.

Test Plan:
- MK=0123456789ABCDEFFEDCBA9876543210, key_valid for 1 cycle -> busy for 32 cycles, keys_valid rises 33 cycles after the handshake, rk0=F12186F9, rk31=9124A012.
- After done, read idx 0 with rk_decrypt=1 -> rk_out=9124A012 next cycle; idx 31 with rk_decrypt=1 -> F12186F9; rk_out_valid pulses exactly one cycle per request.
- key_valid held high during EXPAND with a different key -> ignored; rk31 still 9124A012 and keys_valid rises at the same cycle.
- rst asserted at expansion cycle 10 -> next cycle busy=0, keys_valid=0, key_ready=1; a fresh MK load then completes normally.
- New key in DONE (all-zero MK) -> keys_valid drops the next cycle, 32-cycle re-expansion follows, rk0 matches the software model for MK=0.
- Back-to-back reads idx 0..31 with rk_decrypt=0 -> rk_out sequence equals the software reference with one-cycle latency, no bubbles.
